// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: ALU mode codes, arbiter FSM states and a tag-width helper.
package alu_arbiter_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [7:0] {
    ALU_NON = 8'h00,
    ALU_ADD = 8'h01,
    ALU_SUB = 8'h02,
    ALU_AND = 8'h03,
    ALU_OR  = 8'h04,
    ALU_XOR = 8'h05,
    ALU_SHL = 8'h06,
    ALU_SHR = 8'h07
  } alu_mode_e;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ERR} arb_state_e;

  // A single requester still needs a one-bit tag.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bus of the ALU arbiter.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = alu_arbiter_pkg::id_width(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_mode;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic                 resp_valid;
  logic [ID_W-1:0]      resp_id;
  logic [7:0]           resp_out;
  logic                 resp_carry;
  logic                 resp_zero;
  logic                 resp_err;

  modport master (
    output req_valid, req_mode, req_a, req_b,
    input  req_ready, resp_valid, resp_id, resp_out, resp_carry, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b,
    output req_ready, resp_valid, resp_id, resp_out, resp_carry, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: grants the first valid index after ptr, wrapping at N.
module alu_arbiter_rr #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU between NUM_REQ requesters: round-robin accept, issue, capture, tagged response.
//  state   | meaning
//  IDLE    | waiting; grants one valid requester and latches its op
//  ISSUE   | ALU mode/operands driven for one cycle
//  CAPTURE | mode back to NON, ALU results registered into resp_*
//  ERR     | NON-mode request; error response without touching the ALU
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  alu_arbiter_if.slave      bus,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [7:0]        alu_mode,
  output logic              alu_reset,
  input  logic [7:0]        alu_out,
  input  logic              alu_carry,
  input  logic              alu_zero
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [7:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  alu_mode_e         alu_mode_q, alu_mode_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [7:0]        resp_out_q, resp_out_d;
  logic              resp_carry_q, resp_carry_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0] gnt_vec;
  logic [ID_W-1:0]    gnt_idx;
  logic [7:0]         sel_mode, sel_a, sel_b;

  alu_arbiter_rr #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .valid (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (gnt_vec),
    .idx   (gnt_idx)
  );

  always_comb begin
    sel_mode = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vec[i]) begin
        sel_mode = bus.req_mode[8*i +: 8];
        sel_a    = bus.req_a[8*i +: 8];
        sel_b    = bus.req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_mode_d   = alu_mode_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_out_d   = resp_out_q;
    resp_carry_d = resp_carry_q;
    resp_zero_d  = resp_zero_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          rr_ptr_d = gnt_idx;
          gnt_d    = gnt_idx;
          // A NON request never reaches the ALU, so its last mode and flags survive.
          if (sel_mode == ALU_NON) begin
            state_d = ERR;
          end else begin
            state_d    = ISSUE;
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_mode_d = alu_mode_e'(sel_mode);
          end
        end
      end
      ISSUE: begin
        alu_mode_d = ALU_NON;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        resp_valid_d = 1'b1;
        resp_id_d    = gnt_q;
        resp_out_d   = alu_out;
        resp_carry_d = alu_carry;
        resp_zero_d  = alu_zero;
        resp_err_d   = 1'b0;
        state_d      = IDLE;
      end
      ERR: begin
        resp_valid_d = 1'b1;
        resp_id_d    = gnt_q;
        resp_out_d   = '0;
        resp_carry_d = 1'b0;
        resp_zero_d  = 1'b0;
        resp_err_d   = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_mode_q   <= ALU_NON;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_out_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_mode_q   <= alu_mode_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_out_q   <= resp_out_d;
      resp_carry_q <= resp_carry_d;
      resp_zero_q  <= resp_zero_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE && !reset) ? gnt_vec : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_zero  = resp_zero_q;
  assign bus.resp_err   = resp_err_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_mode       = alu_mode_q;
  assign alu_reset      = reset;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU that latches its mode on non-NON cycles.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_a, alu_b, alu_mode, alu_out;
  logic       alu_reset, alu_carry, alu_zero;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(2)) bus ();

  alu_arbiter #(.NUM_REQ(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_mode  (alu_mode),
    .alu_reset (alu_reset),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero)
  );

  // ALU model: ADD reports signed overflow in carry, SUB reports borrow, shifts report the bit shifted out.
  logic [7:0] m_mode, m_a, m_b;
  always @(posedge clk) begin
    if (alu_reset) begin
      m_mode <= 8'h00;
      m_a    <= 8'h00;
      m_b    <= 8'h00;
    end else if (alu_mode != ALU_NON) begin
      m_mode <= alu_mode;
      m_a    <= alu_a;
      m_b    <= alu_b;
    end
  end

  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    case (m_mode)
      ALU_ADD: begin
        alu_out   = m_a + m_b;
        alu_carry = (m_a[7] == m_b[7]) && (alu_out[7] != m_a[7]);
      end
      ALU_SUB: begin
        alu_out   = m_a - m_b;
        alu_carry = (m_a < m_b);
      end
      ALU_AND: alu_out = m_a & m_b;
      ALU_OR:  alu_out = m_a | m_b;
      ALU_XOR: alu_out = m_a ^ m_b;
      ALU_SHL: begin
        alu_out   = m_a << 1;
        alu_carry = m_a[7];
      end
      ALU_SHR: begin
        alu_out   = m_a >> 1;
        alu_carry = m_a[0];
      end
      default: ;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int r, input alu_mode_e m, input logic [7:0] a, input logic [7:0] b);
    bus.req_mode[8*r +: 8] = m;
    bus.req_a[8*r +: 8]    = a;
    bus.req_b[8*r +: 8]    = b;
  endtask

  task automatic t_accept(input string tag, input int r, input alu_mode_e m,
                          input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    drive(r, m, a, b);
    bus.req_valid = 2'b01 << r;
    #1;
    chk({tag, "_ready"}, bus.req_ready, 2'b01 << r);
  endtask

  task automatic t_issue(input string tag, input alu_mode_e m, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk({tag, "_issue_ready"}, bus.req_ready, 2'b00);
    chk({tag, "_issue_mode"}, alu_mode, m);
    chk({tag, "_issue_a"}, alu_a, a);
    chk({tag, "_issue_b"}, alu_b, b);
  endtask

  task automatic t_capture(input string tag, input logic [7:0] a);
    @(negedge clk);
    #1;
    chk({tag, "_cap_mode"}, alu_mode, ALU_NON);
    chk({tag, "_cap_a_held"}, alu_a, a);
    chk({tag, "_cap_rv"}, bus.resp_valid, 1'b0);
  endtask

  task automatic t_resp(input string tag, input logic id, input logic [7:0] out,
                        input logic c, input logic z, input logic e);
    @(negedge clk);
    #1;
    chk({tag, "_rv"}, bus.resp_valid, 1'b1);
    chk({tag, "_id"}, bus.resp_id, id);
    chk({tag, "_out"}, bus.resp_out, out);
    chk({tag, "_carry"}, bus.resp_carry, c);
    chk({tag, "_zero"}, bus.resp_zero, z);
    chk({tag, "_err"}, bus.resp_err, e);
  endtask

  initial begin
    logic [1:0] exp_ready;
    logic       exp_rv;
    logic       exp_id;

    bus.req_valid = 2'b00;
    bus.req_mode  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset, with a request pending that must not be acknowledged.
    drive(0, ALU_ADD, 8'h11, 8'h22);
    bus.req_valid = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_rv", bus.resp_valid, 1'b0);
    chk("rst_mode", alu_mode, ALU_NON);
    chk("rst_a", alu_a, 8'h00);
    chk("rst_b", alu_b, 8'h00);
    chk("rst_alu_reset", alu_reset, 1'b1);
    chk("rst_out", bus.resp_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    chk("rst_release", alu_reset, 1'b0);

    // Single ADD, req0 wins first after reset.
    t_accept("add", 0, ALU_ADD, 8'h7F, 8'h01);
    t_issue("add", ALU_ADD, 8'h7F, 8'h01);
    t_capture("add", 8'h7F);
    t_resp("add", 1'b0, 8'h80, 1'b1, 1'b0, 1'b0);

    // SUB to zero from req1.
    t_accept("sub", 1, ALU_SUB, 8'h05, 8'h05);
    t_issue("sub", ALU_SUB, 8'h05, 8'h05);
    t_capture("sub", 8'h05);
    t_resp("sub", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("sub_rv_drop", bus.resp_valid, 1'b0);
    chk("sub_out_hold", bus.resp_out, 8'h00);

    // Contention: both held valid for four ops -> 0,1,0,1, accepts 3 cycles apart.
    drive(0, ALU_AND, 8'hF0, 8'h3C);
    drive(1, ALU_OR, 8'h0F, 8'h10);
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      bus.req_valid = (c == 12) ? 2'b00 : 2'b11;
      #1;
      exp_ready = (c < 12 && c % 3 == 0) ? ((c % 6 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rv    = (c > 0 && c % 3 == 0);
      exp_id    = (c % 6 == 0);
      chk($sformatf("cont_ready_c%0d", c), bus.req_ready, exp_ready);
      chk($sformatf("cont_rv_c%0d", c), bus.resp_valid, exp_rv);
      if (exp_rv) begin
        chk($sformatf("cont_id_c%0d", c), bus.resp_id, exp_id);
        chk($sformatf("cont_out_c%0d", c), bus.resp_out, exp_id ? 8'h1F : 8'h30);
      end
    end

    // NON request from req1 (lowest priority but alone) -> error response at T+2.
    t_accept("non", 1, ALU_NON, 8'h12, 8'h34);
    chk("non_mode_t0", alu_mode, ALU_NON);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("non_mode_t1", alu_mode, ALU_NON);
    chk("non_rv_t1", bus.resp_valid, 1'b0);
    t_resp("non", 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("non_mode_t2", alu_mode, ALU_NON);

    // A request raised while busy and dropped before IDLE is ignored.
    t_accept("xor", 0, ALU_XOR, 8'hAA, 8'hFF);
    @(negedge clk);
    drive(1, ALU_ADD, 8'h01, 8'h01);
    bus.req_valid = 2'b10;
    #1;
    chk("drop_ready_issue", bus.req_ready, 2'b00);
    chk("drop_mode_issue", alu_mode, ALU_XOR);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("drop_ready_cap", bus.req_ready, 2'b00);
    t_resp("xor", 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("drop_no_issue", alu_mode, ALU_NON);
      chk("drop_no_resp", bus.resp_valid, 1'b0);
    end

    // Reset during CAPTURE of an AND drops the op.
    t_accept("and", 1, ALU_AND, 8'hFF, 8'h0F);
    t_issue("and", ALU_AND, 8'hFF, 8'h0F);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_alu_reset", alu_reset, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_rv", bus.resp_valid, 1'b0);
    chk("midrst_out", bus.resp_out, 8'h00);
    chk("midrst_id", bus.resp_id, 1'b0);
    chk("midrst_mode", alu_mode, ALU_NON);
    chk("midrst_a", alu_a, 8'h00);
    chk("midrst_b", alu_b, 8'h00);
    chk("midrst_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk("midrst_rv_after", bus.resp_valid, 1'b0);
    @(negedge clk);
    drive(0, ALU_ADD, 8'h01, 8'h02);
    drive(1, ALU_SUB, 8'h09, 8'h01);
    bus.req_valid = 2'b11;
    #1;
    chk("midrst_req0_first", bus.req_ready, 2'b01);
    t_issue("post", ALU_ADD, 8'h01, 8'h02);
    t_capture("post", 8'h01);
    t_resp("post", 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    // SHR leaves carry/zero set; they persist while the ALU sees NON.
    t_accept("shr", 0, ALU_SHR, 8'h01, 8'h00);
    t_issue("shr", ALU_SHR, 8'h01, 8'h00);
    t_capture("shr", 8'h01);
    t_resp("shr", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("persist_mode_%0d", c), alu_mode, ALU_NON);
      chk($sformatf("persist_alu_zc_%0d", c), {alu_zero, alu_carry}, 2'b11);
      chk($sformatf("persist_resp_zc_%0d", c), {bus.resp_zero, bus.resp_carry}, 2'b11);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
